// File: rtl/audio_mem_arb.sv
// Two-port read arbiter that shares one VRAM port and one tile-memory port between an
// audio DMA requester and a host requester, with bounded host starvation.
module audio_mem_arb #(
    parameter int ADDR_W     = 16,
    parameter int STARVE_MAX = 7
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              audio_req_i,
    input  logic              audio_tile_i,
    input  logic [ADDR_W-1:0] audio_addr_i,
    output logic              audio_ack_o,
    output logic [15:0]       audio_word_o,
    input  logic              host_req_i,
    input  logic              host_tile_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic              host_ack_o,
    output logic [15:0]       host_word_o,
    output logic              vram_sel_o,
    output logic [ADDR_W-1:0] vram_addr_o,
    input  logic [15:0]       vram_data_i,
    input  logic              vram_busy_i,
    output logic              tile_sel_o,
    output logic [ADDR_W-1:0] tile_addr_o,
    input  logic [15:0]       tile_data_i,
    input  logic              tile_busy_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_ACK} state_t;

    state_t             state;
    logic [CNT_W-1:0]   starve_cnt;
    logic               owner_host;
    logic               tgt_tile;

    logic               audio_elig;
    logic               host_elig;
    logic               starved;
    logic               host_wins;
    logic               audio_wins;
    logic               grant_audio;
    logic               grant_host;
    logic               grant_tile;
    logic [ADDR_W-1:0]  grant_addr;
    logic [15:0]        rd_data;

    assign audio_elig = audio_req_i & ~(audio_tile_i ? tile_busy_i : vram_busy_i);
    assign host_elig  = host_req_i  & ~(host_tile_i  ? tile_busy_i : vram_busy_i);
    assign starved    = (starve_cnt == CNT_W'(STARVE_MAX));
    assign host_wins  = host_elig & (~audio_elig | starved);
    assign audio_wins = audio_elig & ~host_wins;

    // Priority is decided before masking the requester being acked, so a still-high
    // req in its own ack cycle costs one idle cycle rather than handing the slot away.
    assign grant_audio = audio_wins & ~audio_ack_o;
    assign grant_host  = host_wins & ~host_ack_o;
    assign grant_tile  = grant_host ? host_tile_i : audio_tile_i;
    assign grant_addr  = grant_host ? host_addr_i : audio_addr_i;
    assign rd_data     = tgt_tile ? tile_data_i : vram_data_i;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state        <= ARB_IDLE;
            starve_cnt   <= '0;
            owner_host   <= 1'b0;
            tgt_tile     <= 1'b0;
            audio_ack_o  <= 1'b0;
            host_ack_o   <= 1'b0;
            audio_word_o <= '0;
            host_word_o  <= '0;
            vram_sel_o   <= 1'b0;
            tile_sel_o   <= 1'b0;
            vram_addr_o  <= '0;
            tile_addr_o  <= '0;
        end else begin
            audio_ack_o <= 1'b0;
            host_ack_o  <= 1'b0;
            vram_sel_o  <= 1'b0;
            tile_sel_o  <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_audio || grant_host) begin
                        owner_host <= grant_host;
                        tgt_tile   <= grant_tile;
                        if (grant_tile) begin
                            tile_sel_o  <= 1'b1;
                            tile_addr_o <= grant_addr;
                        end else begin
                            vram_sel_o  <= 1'b1;
                            vram_addr_o <= grant_addr;
                        end
                        if (grant_host)
                            starve_cnt <= '0;
                        else if (host_req_i && !starved)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: state <= ARB_ACK;
                ARB_ACK: begin
                    if (owner_host) begin
                        host_word_o <= rd_data;
                        host_ack_o  <= 1'b1;
                    end else begin
                        audio_word_o <= rd_data;
                        audio_ack_o  <= 1'b1;
                    end
                    state <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_mem_arb.sv
// Scoreboard bench for audio_mem_arb: stimulus pushes expected acks per port,
// a negedge monitor pops and compares word and ack cycle.
module tb_audio_mem_arb;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        audio_req_i, audio_tile_i, host_req_i, host_tile_i;
    logic [15:0] audio_addr_i, host_addr_i;
    logic        audio_ack_o, host_ack_o;
    logic [15:0] audio_word_o, host_word_o;
    logic        vram_sel_o, tile_sel_o;
    logic [15:0] vram_addr_o, tile_addr_o;
    logic [15:0] vram_data_i, tile_data_i;
    logic        vram_busy_i, tile_busy_i;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] word;
        int          due;
    } exp_t;

    exp_t aq[$];
    exp_t hq[$];

    audio_mem_arb #(.ADDR_W(16), .STARVE_MAX(7)) dut (
        .clk(clk), .reset_i(reset_i),
        .audio_req_i(audio_req_i), .audio_tile_i(audio_tile_i), .audio_addr_i(audio_addr_i),
        .audio_ack_o(audio_ack_o), .audio_word_o(audio_word_o),
        .host_req_i(host_req_i), .host_tile_i(host_tile_i), .host_addr_i(host_addr_i),
        .host_ack_o(host_ack_o), .host_word_o(host_word_o),
        .vram_sel_o(vram_sel_o), .vram_addr_o(vram_addr_o),
        .vram_data_i(vram_data_i), .vram_busy_i(vram_busy_i),
        .tile_sel_o(tile_sel_o), .tile_addr_o(tile_addr_o),
        .tile_data_i(tile_data_i), .tile_busy_i(tile_busy_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory models: data appears the cycle after the read strobe, zero otherwise.
    always @(posedge clk) begin
        vram_data_i <= vram_sel_o ? ((vram_addr_o == 16'h1234) ? 16'hBEEF : (vram_addr_o ^ 16'hA5A5)) : 16'h0000;
        tile_data_i <= tile_sel_o ? (tile_addr_o ^ 16'h0F0F) : 16'h0000;
    end

    always @(negedge clk) begin
        if (!reset_i && audio_ack_o) begin
            n_vec++;
            if (aq.size() == 0) begin
                n_bad++;
                $display("FAIL audio_unexpected_ack cycle=%0d word=%h", cyc, audio_word_o);
            end else begin
                exp_t e;
                e = aq.pop_front();
                if (audio_word_o !== e.word || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL audio_ack got word=%h cycle=%0d, want word=%h cycle=%0d",
                             audio_word_o, cyc, e.word, e.due);
                end
            end
        end
        if (!reset_i && host_ack_o) begin
            n_vec++;
            if (hq.size() == 0) begin
                n_bad++;
                $display("FAIL host_unexpected_ack cycle=%0d word=%h", cyc, host_word_o);
            end else begin
                exp_t e;
                e = hq.pop_front();
                if (host_word_o !== e.word || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL host_ack got word=%h cycle=%0d, want word=%h cycle=%0d",
                             host_word_o, cyc, e.word, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic go_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_a(input logic [15:0] w, input int due);
        exp_t e;
        e.word = w;
        e.due  = due;
        aq.push_back(e);
    endtask

    task automatic push_h(input logic [15:0] w, input int due);
        exp_t e;
        e.word = w;
        e.due  = due;
        hq.push_back(e);
    endtask

    // Single well-behaved transaction: req held through the ack cycle, then dropped.
    task automatic xact(input bit host, input bit tile, input logic [15:0] addr, input logic [15:0] word);
        int  c;
        bit  got;
        c   = cyc;
        got = 1'b0;
        if (host) begin
            host_tile_i = tile; host_addr_i = addr; host_req_i = 1'b1;
            push_h(word, c + 3);
        end else begin
            audio_tile_i = tile; audio_addr_i = addr; audio_req_i = 1'b1;
            push_a(word, c + 3);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if ((host && host_ack_o) || (!host && audio_ack_o)) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_bad++;
            $display("FAIL xact_timeout host=%0d addr=%h", host, addr);
        end
        @(posedge clk);
        #1;
        if (host) host_req_i = 1'b0;
        else      audio_req_i = 1'b0;
    endtask

    initial begin
        int c;
        reset_i = 1'b1;
        audio_req_i = 1'b0; audio_tile_i = 1'b0; audio_addr_i = 16'h0;
        host_req_i = 1'b0;  host_tile_i = 1'b0;  host_addr_i = 16'h0;
        vram_busy_i = 1'b0; tile_busy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_audio_ack", {31'b0, audio_ack_o}, 32'h0);
        chk("rst_host_ack", {31'b0, host_ack_o}, 32'h0);
        chk("rst_sels", {30'b0, vram_sel_o, tile_sel_o}, 32'h0);
        chk("rst_words", {audio_word_o, host_word_o}, 32'h0);
        chk("rst_addrs", {vram_addr_o, tile_addr_o}, 32'h0);
        reset_i = 1'b0;
        go_to(cyc + 2);

        // Audio-only VRAM read with 3-cycle latency
        c = cyc;
        audio_tile_i = 1'b0; audio_addr_i = 16'h1234; audio_req_i = 1'b1;
        push_a(16'hBEEF, c + 3);
        go_to(c + 1);
        chk("issue_vram_sel", {31'b0, vram_sel_o}, 32'h1);
        chk("issue_vram_addr", {16'b0, vram_addr_o}, 32'h1234);
        chk("issue_tile_sel", {31'b0, tile_sel_o}, 32'h0);
        go_to(c + 2);
        chk("ack_vram_sel_low", {31'b0, vram_sel_o}, 32'h0);
        chk("vram_addr_hold", {16'b0, vram_addr_o}, 32'h1234);
        go_to(c + 4);
        audio_req_i = 1'b0;
        go_to(c + 6);

        // Host-only tile read; audio word must keep its value
        xact(1'b1, 1'b1, 16'h3000, 16'h3F0F);
        chk("audio_word_hold", {16'b0, audio_word_o}, 32'hBEEF);
        go_to(cyc + 2);

        // Audio drops req during ISSUE: still exactly one ack
        c = cyc;
        audio_tile_i = 1'b1; audio_addr_i = 16'h2222; audio_req_i = 1'b1;
        push_a(16'h2D2D, c + 3);
        go_to(c + 1);
        audio_req_i = 1'b0;
        go_to(c + 8);

        // Reset during ISSUE: outputs clear at once, no ack, then a clean retry
        c = cyc;
        audio_tile_i = 1'b0; audio_addr_i = 16'h0500; audio_req_i = 1'b1;
        go_to(c + 1);
        chk("pre_rst_vram_sel", {31'b0, vram_sel_o}, 32'h1);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_vram_sel", {31'b0, vram_sel_o}, 32'h0);
        chk("mid_rst_ack", {30'b0, audio_ack_o, host_ack_o}, 32'h0);
        chk("mid_rst_addr", {16'b0, vram_addr_o}, 32'h0);
        chk("mid_rst_word", {audio_word_o, host_word_o}, 32'h0);
        audio_req_i = 1'b0;
        go_to(c + 2);
        reset_i = 1'b0;
        go_to(c + 7);
        xact(1'b0, 1'b0, 16'h0500, 16'hA0A5);
        go_to(cyc + 2);

        // Audio blocked on busy VRAM must not hold back host on tile memory
        c = cyc;
        vram_busy_i = 1'b1;
        audio_tile_i = 1'b0; audio_addr_i = 16'h0040; audio_req_i = 1'b1;
        host_tile_i = 1'b1;  host_addr_i = 16'h3000;  host_req_i = 1'b1;
        push_h(16'h3F0F, c + 3);
        push_a(16'hA5E5, c + 8);
        go_to(c + 1);
        chk("hol_tile_sel", {31'b0, tile_sel_o}, 32'h1);
        chk("hol_vram_sel", {31'b0, vram_sel_o}, 32'h0);
        chk("hol_tile_addr", {16'b0, tile_addr_o}, 32'h3000);
        go_to(c + 4);
        host_req_i = 1'b0;
        go_to(c + 5);
        vram_busy_i = 1'b0;
        go_to(c + 6);
        chk("late_vram_sel", {31'b0, vram_sel_o}, 32'h1);
        chk("late_vram_addr", {16'b0, vram_addr_o}, 32'h0040);
        go_to(c + 9);
        audio_req_i = 1'b0;
        go_to(c + 11);

        // Both on VRAM continuously: 7 audio grants then 1 host, twice
        c = cyc;
        audio_tile_i = 1'b0; audio_addr_i = 16'h0100; audio_req_i = 1'b1;
        host_tile_i = 1'b0;  host_addr_i = 16'h0200;  host_req_i = 1'b1;
        for (int i = 0; i < 7; i++) push_a(16'hA4A5, c + 3 + 4 * i);
        push_h(16'hA7A5, c + 30);
        for (int i = 0; i < 7; i++) push_a(16'hA4A5, c + 33 + 4 * i);
        push_h(16'hA7A5, c + 60);
        go_to(c + 27);
        chk("starve_full_1", {29'b0, dut.starve_cnt}, 32'h7);
        go_to(c + 28);
        chk("starve_clear_1", {29'b0, dut.starve_cnt}, 32'h0);
        go_to(c + 57);
        chk("starve_full_2", {29'b0, dut.starve_cnt}, 32'h7);
        go_to(c + 58);
        audio_req_i = 1'b0;
        chk("starve_clear_2", {29'b0, dut.starve_cnt}, 32'h0);
        go_to(c + 61);
        host_req_i = 1'b0;
        go_to(c + 70);

        chk("audio_queue_drained", aq.size(), 32'h0);
        chk("host_queue_drained", hq.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
